// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one 000/111 Mealy detector across NCH bit channels.
// Optional per-channel saturating hit counters are enabled with `define SEQDET_HIT_COUNT_EN.
module seq_det_sched #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CHW = $clog2(NCH),
  parameter int unsigned CW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] in_valid,
  input  logic [NCH-1:0] in_bit,
  output logic [NCH-1:0] in_ready,
  output logic           hit_valid,
  output logic [CHW-1:0] hit_ch,
  output logic           hit_kind
`ifdef SEQDET_HIT_COUNT_EN
  ,
  input  logic [CHW-1:0] cnt_sel,
  input  logic           clr_cnt,
  output logic [CW-1:0]  cnt_val
`endif
);

  logic [NCH-1:0]       last_q;
  logic [NCH-1:0][1:0]  run_q;
  logic [CHW-1:0]       rr_q, rr_d;
  logic                 hit_valid_q;
  logic [CHW-1:0]       hit_ch_q;
  logic                 hit_kind_q;

  logic                 grant_found;
  logic [CHW-1:0]       grant_idx;
  logic                 accept;
  logic                 cur_last, cur_bit;
  logic [1:0]           cur_run;
  logic                 next_last;
  logic [1:0]           next_run;
  logic                 hit;

  // First valid channel at or after rr, wrapping modulo NCH.
  always_comb begin
    int unsigned j;
    j           = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      j = (int'(rr_q) + i) % NCH;
      if (!grant_found && in_valid[j]) begin
        grant_found = 1'b1;
        grant_idx   = CHW'(j);
      end
    end
  end

  assign accept = grant_found && !rst;

  always_comb begin
    in_ready = '0;
    if (accept) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  assign rr_d = (grant_idx == CHW'(NCH - 1)) ? '0 : grant_idx + 1'b1;

  // Mealy step on the granted channel's restored context.
  assign cur_last = last_q[grant_idx];
  assign cur_run  = run_q[grant_idx];
  assign cur_bit  = in_bit[grant_idx];

  always_comb begin
    next_last = cur_last;
    next_run  = cur_run;
    hit       = 1'b0;
    if (cur_run == 2'd0 || cur_bit != cur_last) begin
      next_last = cur_bit;
      next_run  = 2'd1;
    end else if (cur_run == 2'd1) begin
      next_run = 2'd2;
    end else begin
      next_run = 2'd2;
      hit      = accept;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q      <= '0;
      run_q       <= '0;
      rr_q        <= '0;
      hit_valid_q <= 1'b0;
      hit_ch_q    <= '0;
      hit_kind_q  <= 1'b0;
    end else begin
      if (accept) begin
        last_q[grant_idx] <= next_last;
        run_q[grant_idx]  <= next_run;
        rr_q              <= rr_d;
      end
      hit_valid_q <= hit;
      if (hit) begin
        hit_ch_q   <= grant_idx;
        hit_kind_q <= cur_bit;
      end
    end
  end

  assign hit_valid = hit_valid_q;
  assign hit_ch    = hit_ch_q;
  assign hit_kind  = hit_kind_q;

`ifdef SEQDET_HIT_COUNT_EN
  logic [NCH-1:0][CW-1:0] cnt_q;

  // A hit coinciding with a clear on the same channel leaves the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (hit && grant_idx == CHW'(i)) begin
          if (clr_cnt && cnt_sel == CHW'(i)) begin
            cnt_q[i] <= CW'(1);
          end else if (cnt_q[i] != {CW{1'b1}}) begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else if (clr_cnt && cnt_sel == CHW'(i)) begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign cnt_val = cnt_q[cnt_sel];
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed self-checking bench for seq_det_sched with NCH=4 (CW=2 for the counter option).
module tb_seq_det_sched;

  localparam int unsigned NCH = 4;
  localparam int unsigned CHW = 2;
  localparam int unsigned CW  = 2;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] in_valid;
  logic [NCH-1:0] in_bit;
  logic [NCH-1:0] in_ready;
  logic           hit_valid;
  logic [CHW-1:0] hit_ch;
  logic           hit_kind;
`ifdef SEQDET_HIT_COUNT_EN
  logic [CHW-1:0] cnt_sel;
  logic           clr_cnt;
  logic [CW-1:0]  cnt_val;
`endif

  int n_vec;
  int n_err;
  int hold_ch;
  logic hold_kind;

  seq_det_sched #(.NCH(NCH), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .hit_valid (hit_valid),
    .hit_ch    (hit_ch),
    .hit_kind  (hit_kind)
`ifdef SEQDET_HIT_COUNT_EN
    ,
    .cnt_sel   (cnt_sel),
    .clr_cnt   (clr_cnt),
    .cnt_val   (cnt_val)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Entered and left at posedge+1; in_ready is checked before the edge, hit outputs after it.
  task automatic xfer(input logic [3:0] v, input logic [3:0] b, input logic [3:0] exp_rdy,
                      input logic exp_hit, input int exp_ch, input logic exp_kind);
    in_valid = v;
    in_bit   = b;
    #1;
    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    check_eq("hit_valid", 32'(hit_valid), 32'(exp_hit));
    if (exp_hit) begin
      hold_ch   = exp_ch;
      hold_kind = exp_kind;
    end
    check_eq("hit_ch", 32'(hit_ch), 32'(hold_ch));
    check_eq("hit_kind", 32'(hit_kind), 32'(hold_kind));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 4'b1111;
    in_bit   = 4'b1111;
    #1;
    check_eq("ready_in_rst", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = '0;
    hold_ch   = 0;
    hold_kind = 1'b0;
    check_eq("rst_hit_valid", 32'(hit_valid), 32'd0);
    check_eq("rst_hit_ch", 32'(hit_ch), 32'd0);
    check_eq("rst_hit_kind", 32'(hit_kind), 32'd0);
  endtask

  bit t1_bits [18] = '{1, 0, 0, 0, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  bit t1_hit  [18] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 1};

  initial begin
    int r;
    int g;
    logic rb;
    n_vec    = 0;
    n_err    = 0;
    hold_ch  = 0;
    hold_kind = 1'b0;
    rst      = 1'b1;
    in_valid = '0;
    in_bit   = '0;
`ifdef SEQDET_HIT_COUNT_EN
    cnt_sel  = '0;
    clr_cnt  = 1'b0;
`endif
    @(posedge clk);
    #1;
    do_reset();

    // Single channel, overlapping 000/111 detection.
    for (int i = 0; i < 18; i++) begin
      xfer(4'b0001, {3'b000, t1_bits[i]}, 4'b0001, t1_hit[i], 0, t1_bits[i]);
    end

    // All four valid: strict rotation, ch0 all ones, ch1 all zeros, ch2/ch3 alternating.
    do_reset();
    for (int n = 0; n < 16; n++) begin
      r  = n / 4;
      g  = n % 4;
      rb = r[0];
      xfer(4'b1111, {rb, rb, 1'b0, 1'b1}, 4'b0001 << g, (n >= 8) && (g < 2), g, g == 0);
    end

    // Reset mid-run discards the partial history.
    do_reset();
    xfer(4'b0001, 4'b0001, 4'b0001, 1'b0, 0, 1'b0);
    xfer(4'b0001, 4'b0001, 4'b0001, 1'b0, 0, 1'b0);
    do_reset();
    xfer(4'b0001, 4'b0001, 4'b0001, 1'b0, 0, 1'b0);
    xfer(4'b0001, 4'b0001, 4'b0001, 1'b0, 0, 1'b0);
    xfer(4'b0001, 4'b0001, 4'b0001, 1'b1, 0, 1'b1);

    // Only ch2/ch3 valid; ch3 drops out once and its context must survive.
    do_reset();
    xfer(4'b1100, 4'b0100, 4'b0100, 1'b0, 0, 1'b0);
    xfer(4'b1100, 4'b0100, 4'b1000, 1'b0, 0, 1'b0);
    xfer(4'b1100, 4'b0100, 4'b0100, 1'b0, 0, 1'b0);
    xfer(4'b0100, 4'b0100, 4'b0100, 1'b1, 2, 1'b1);
    xfer(4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b0);
    xfer(4'b1100, 4'b0100, 4'b1000, 1'b0, 0, 1'b0);
    xfer(4'b1100, 4'b0100, 4'b0100, 1'b1, 2, 1'b1);
    xfer(4'b1100, 4'b0100, 4'b1000, 1'b1, 3, 1'b0);

`ifdef SEQDET_HIT_COUNT_EN
    begin
      int exp_cnt [7] = '{0, 0, 1, 2, 3, 3, 3};
      do_reset();
      cnt_sel = 2'd1;
      #1;
      check_eq("cnt_rst", 32'(cnt_val), 32'd0);
      for (int k = 0; k < 7; k++) begin
        xfer(4'b0010, 4'b0010, 4'b0010, k >= 2, 1, 1'b1);
        check_eq("cnt_sat", 32'(cnt_val), 32'(exp_cnt[k]));
      end
      clr_cnt = 1'b1;
      xfer(4'b0010, 4'b0010, 4'b0010, 1'b1, 1, 1'b1);
      clr_cnt = 1'b0;
      check_eq("cnt_clr_hit", 32'(cnt_val), 32'd1);
      for (int k = 0; k < 3; k++) begin
        xfer(4'b0001, 4'b0001, 4'b0001, k == 2, 0, 1'b1);
      end
      cnt_sel = 2'd0;
      #1;
      check_eq("cnt_ch0", 32'(cnt_val), 32'd1);
      clr_cnt = 1'b1;
      xfer(4'b0010, 4'b0010, 4'b0010, 1'b1, 1, 1'b1);
      clr_cnt = 1'b0;
      check_eq("cnt_ch0_clr", 32'(cnt_val), 32'd0);
      cnt_sel = 2'd1;
      #1;
      check_eq("cnt_ch1_inc", 32'(cnt_val), 32'd2);
      do_reset();
      #1;
      check_eq("cnt_rst2", 32'(cnt_val), 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
